// File: rtl/uart_led_cmd.sv
// LED command decoder fed by the UART receiver: edge-detects the receiver's ready level,
// parses 'S'/'B'/'C' commands and drives static or blinking LED patterns.
module uart_led_cmd #(
   parameter int DATA_BITS      = 8,
   parameter int BLINK_CYCLES   = 25_000_000,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [DATA_BITS-1:0] i_data_rx,
   input  logic                 i_ready_rx,
   output logic [DATA_BITS-1:0] o_led,
   output logic                 o_cmd_done,
   output logic                 o_cmd_err
);

   localparam int BW = $clog2(BLINK_CYCLES);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [DATA_BITS-1:0] OP_SET   = DATA_BITS'(8'h53);
   localparam logic [DATA_BITS-1:0] OP_BLINK = DATA_BITS'(8'h42);
   localparam logic [DATA_BITS-1:0] OP_CLEAR = DATA_BITS'(8'h43);

   typedef enum logic {CMD_IDLE, CMD_ARG} state_t;

   state_t               state, state_nxt;
   logic                 ready_d;
   logic                 strb;
   logic                 op_blink;
   logic [TW-1:0]        tcnt;
   logic [BW-1:0]        bcnt;
   logic                 phase;
   logic [DATA_BITS-1:0] led_reg;
   logic [DATA_BITS-1:0] blink_mask;
   logic                 arm, do_set, do_blink, do_clear, done_nxt, err_nxt;

   // ready_d comes out of reset high so a ready level held across release is not a new frame
   assign strb = i_ready_rx & ~ready_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= CMD_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      arm       = 1'b0;
      do_set    = 1'b0;
      do_blink  = 1'b0;
      do_clear  = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         CMD_IDLE: begin
            if (strb) begin
               if (i_data_rx == OP_SET || i_data_rx == OP_BLINK) begin
                  arm       = 1'b1;
                  state_nxt = CMD_ARG;
               end else if (i_data_rx == OP_CLEAR) begin
                  do_clear = 1'b1;
                  done_nxt = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         CMD_ARG: begin
            // a strobe landing on the timeout cycle still applies the command
            if (strb) begin
               do_blink  = op_blink;
               do_set    = ~op_blink;
               done_nxt  = 1'b1;
               state_nxt = CMD_IDLE;
            end else if (tcnt == TIMEOUT_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = CMD_IDLE;
            end
         end
         default: state_nxt = CMD_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ready_d    <= 1'b1;
         op_blink   <= 1'b0;
         tcnt       <= '0;
         led_reg    <= '0;
         blink_mask <= '0;
         o_cmd_done <= 1'b0;
         o_cmd_err  <= 1'b0;
      end else begin
         ready_d    <= i_ready_rx;
         o_cmd_done <= done_nxt;
         o_cmd_err  <= err_nxt;
         if (arm) begin
            op_blink <= (i_data_rx == OP_BLINK);
         end
         if (state == CMD_ARG) begin
            tcnt <= tcnt + 1'b1;
         end else begin
            tcnt <= '0;
         end
         if (do_clear) begin
            led_reg    <= '0;
            blink_mask <= '0;
         end else if (do_set) begin
            led_reg <= i_data_rx;
         end else if (do_blink) begin
            blink_mask <= i_data_rx;
         end
      end
   end

   // free-running blink timebase, restarted when a new blink mask is loaded
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bcnt  <= '0;
         phase <= 1'b0;
      end else if (do_blink) begin
         bcnt  <= '0;
         phase <= 1'b0;
      end else if (bcnt == BLINK_LAST) begin
         bcnt  <= '0;
         phase <= ~phase;
      end else begin
         bcnt <= bcnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_led <= '0;
      end else begin
         o_led <= led_reg ^ (blink_mask & {DATA_BITS{phase}});
      end
   end

endmodule

// File: tb/tb_uart_led_cmd.sv
// Randomised bench for uart_led_cmd: an edge-indexed command model is compared with the
// outputs every cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_led_cmd;

   localparam int BLINK = 4;
   localparam int TMO   = 20;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       ready_rx = 1'b0;
   logic [7:0] data_rx  = 8'h00;
   logic [7:0] led;
   logic       done, err;

   uart_led_cmd #(
      .DATA_BITS(8),
      .BLINK_CYCLES(BLINK),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_data_rx(data_rx),
      .i_ready_rx(ready_rx),
      .o_led(led),
      .o_cmd_done(done),
      .o_cmd_err(err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int passes   = 0;
   int done_cnt = 0;
   int err_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Model: k counts clock edges since reset; the blink phase after edge k is
   // floor((k - base) / BLINK) mod 2, where base is the edge a blink mask was loaded.
   int         k       = 0;
   int         base    = 0;
   int         op_edge = 0;
   bit         pend    = 0;
   bit         pend_b  = 0;
   bit         prev_rdy = 1;
   bit         m_strb;
   logic [7:0] m_led   = 8'h00;
   logic [7:0] m_mask  = 8'h00;
   logic [7:0] exp_led = 8'h00;
   bit         exp_done = 0;
   bit         exp_err  = 0;

   function automatic bit phase_at(input int kk, input int bb);
      return bit'(((kk - bb) / BLINK) % 2);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k = 0; base = 0; pend = 0; prev_rdy = 1;
         m_led = 8'h00; m_mask = 8'h00;
         exp_led = 8'h00; exp_done = 0; exp_err = 0;
      end else begin
         exp_led  = m_led ^ (m_mask & {8{phase_at(k, base)}});
         k        = k + 1;
         exp_done = 0;
         exp_err  = 0;
         m_strb   = ready_rx && !prev_rdy;
         prev_rdy = ready_rx;
         if (pend) begin
            if (m_strb) begin
               if (pend_b) begin
                  m_mask = data_rx;
                  base   = k;
               end else begin
                  m_led = data_rx;
               end
               exp_done = 1;
               pend     = 0;
            end else if (k - op_edge == TMO) begin
               exp_err = 1;
               pend    = 0;
            end
         end else if (m_strb) begin
            if (data_rx == 8'h53 || data_rx == 8'h42) begin
               pend    = 1;
               pend_b  = (data_rx == 8'h42);
               op_edge = k;
            end else if (data_rx == 8'h43) begin
               m_led    = 8'h00;
               m_mask   = 8'h00;
               exp_done = 1;
            end else begin
               exp_err = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("model_led", 32'(led), 32'(exp_led));
      check("model_done", 32'(done), 32'(exp_done));
      check("model_err", 32'(err), 32'(exp_err));
      if (done) done_cnt++;
      if (err) err_cnt++;
   end

   task automatic send(input logic [7:0] b, input int hold, input int gap,
                       output bit d, output bit e);
      @(negedge clk);
      data_rx  = b;
      ready_rx = 1'b1;
      @(negedge clk);
      d = done;
      e = err;
      repeat (hold - 1) @(negedge clk);
      ready_rx = 1'b0;
      data_rx  = 8'($urandom);
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      bit d, e;
      int c0, e0, n, bad;
      logic [7:0] cap [16];

      repeat (3) @(negedge clk);
      check("reset_led", 32'(led), 32'h00);
      check("reset_done", 32'(done), 32'h0);
      check("reset_err", 32'(err), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // set with long ready levels
      c0 = done_cnt; e0 = err_cnt;
      send(8'h53, 16, 3, d, e);
      check("s_op_done", 32'(d), 32'h0);
      send(8'hA5, 16, 3, d, e);
      check("s_arg_done", 32'(d), 32'h1);
      check("s_arg_err", 32'(e), 32'h0);
      check("s_done_count", 32'(done_cnt - c0), 32'd1);
      check("s_err_count", 32'(err_cnt - e0), 32'd0);
      check("s_led", 32'(led), 32'hA5);

      // blink 0x0F over 0xA5
      send(8'h42, 4, 2, d, e);
      @(negedge clk);
      data_rx = 8'h0F; ready_rx = 1'b1;
      @(negedge clk);
      check("b_done", 32'(done), 32'h1);
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         cap[j] = led;
      end
      ready_rx = 1'b0;
      check("b_led0", 32'(cap[0]), 32'hA5);
      check("b_led3", 32'(cap[3]), 32'hA5);
      check("b_led4", 32'(cap[4]), 32'hAA);
      check("b_led7", 32'(cap[7]), 32'hAA);
      check("b_led8", 32'(cap[8]), 32'hA5);
      check("b_led12", 32'(cap[12]), 32'hAA);
      repeat (3) @(negedge clk);

      // clear
      send(8'h43, 2, 1, d, e);
      check("c_done", 32'(d), 32'h1);
      bad = 0;
      for (int j = 0; j < 50; j++) begin
         @(negedge clk);
         if (led != 8'h00) bad++;
      end
      check("c_led_zero_cycles_bad", 32'(bad), 32'd0);

      // bad opcode, then timeout
      send(8'h7E, 2, 2, d, e);
      check("bad_err", 32'(e), 32'h1);
      check("bad_done", 32'(d), 32'h0);
      check("bad_led", 32'(led), 32'h00);
      send(8'h53, 1, 0, d, e);
      n = 0;
      while (!err && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("tmo_err", 32'(err), 32'h1);
      check("tmo_latency", 32'(n), 32'(TMO));
      repeat (2) @(negedge clk);
      send(8'h53, 2, 1, d, e);
      send(8'h01, 2, 3, d, e);
      check("tmo_then_set_led", 32'(led), 32'h01);

      // argument strobe on the exact timeout cycle, with 0x43 as argument
      @(negedge clk);
      data_rx = 8'h53; ready_rx = 1'b1;
      @(negedge clk);
      ready_rx = 1'b0;
      repeat (19) @(negedge clk);
      data_rx = 8'h43; ready_rx = 1'b1;
      @(negedge clk);
      check("edge_done", 32'(done), 32'h1);
      check("edge_err", 32'(err), 32'h0);
      @(negedge clk);
      ready_rx = 1'b0;
      repeat (3) @(negedge clk);
      check("edge_led", 32'(led), 32'h43);

      // reset during CMD_ARG with ready high across release
      send(8'h53, 1, 2, d, e);
      @(negedge clk);
      data_rx = 8'h99; ready_rx = 1'b1;
      #2 rst_n = 1'b0;
      #1 check("rst_led_async", 32'(led), 32'h00);
      c0 = done_cnt; e0 = err_cnt;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("rst_no_done", 32'(done_cnt - c0), 32'd0);
      check("rst_no_err", 32'(err_cnt - e0), 32'd0);
      ready_rx = 1'b0;
      repeat (2) @(negedge clk);
      send(8'h53, 2, 1, d, e);
      send(8'h3C, 2, 3, d, e);
      check("rst_then_set_led", 32'(led), 32'h3C);

      // randomised command traffic, checked by the model each cycle
      for (int i = 0; i < 300; i++) begin
         int r;
         logic [7:0] b;
         r = $urandom_range(0, 9);
         if (r < 3)      b = 8'h53;
         else if (r < 5) b = 8'h42;
         else if (r < 6) b = 8'h43;
         else if (r < 7) b = 8'h7E;
         else            b = 8'($urandom);
         send(b, $urandom_range(1, 6), $urandom_range(1, 4), d, e);
         if ($urandom_range(0, 9) == 0) repeat ($urandom_range(15, 24)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
